// File: rtl/usb_rx_pkg.sv
// Shared USB full-speed receive timing constants, used by the bit timer,
// shift register and receive control unit.
package usb_rx_pkg;

    localparam int unsigned CLKS_PER_BIT  = 8;
    localparam int unsigned SAMPLE_POINT  = 3;
    localparam int unsigned STUFF_LEN     = 6;
    localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and a programmable rollover value;
// wraps to 0 after reaching rollover_val.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    assign rollover_flag = (count_out == rollover_val);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= rollover_flag ? '0 : count_out + NUM_CNT_BITS'(1);
    end

endmodule

// File: rtl/usb_rx_timer.sv
// USB full-speed receive bit timer: recovers bit phase from line edges, strobes
// the shift register once per data bit, strips stuffed bits and flags violations.
module usb_rx_timer
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_en,
    output logic byte_rcvd,
    output logic stuff_err
);

    localparam int unsigned PHASE_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned ONES_W  = $clog2(STUFF_LEN + 1);
    localparam int unsigned BIT_W   = $clog2(BITS_PER_BYTE);

    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);
    localparam logic [ONES_W-1:0]  ONES_MAX     = ONES_W'(STUFF_LEN);
    localparam logic [BIT_W-1:0]   BIT_LAST     = BIT_W'(BITS_PER_BYTE - 1);

    logic [PHASE_W-1:0] phase;
    logic [ONES_W-1:0]  ones_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sample;
    logic               stuffed;
    logic               byte_last;

    // Sampling decodes the current phase, so an edge landing on the sample
    // point still samples before the phase reloads.
    assign sample   = rcving && (phase == PHASE_SAMPLE);
    assign stuffed  = (ones_cnt == ONES_MAX);
    assign shift_en = sample && !stuffed;

    // The edge cycle itself is phase 0, hence the reload to 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            phase <= '0;
        else if (d_edge)
            phase <= PHASE_W'(1);
        else if (!rcving)
            phase <= '0;
        else if (phase == PHASE_LAST)
            phase <= '0;
        else
            phase <= phase + PHASE_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            ones_cnt <= '0;
        else if (!rcving)
            ones_cnt <= '0;
        else if (sample) begin
            if (stuffed || !d_orig)
                ones_cnt <= '0;
            else
                ones_cnt <= ones_cnt + ONES_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            stuff_err <= 1'b0;
        else if (!rcving)
            stuff_err <= 1'b0;
        else if (sample && stuffed && d_orig)
            stuff_err <= 1'b1;
    end

    flex_counter #(
        .NUM_CNT_BITS(BIT_W)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!rcving),
        .count_enable (shift_en),
        .rollover_val (BIT_LAST),
        .count_out    (bit_cnt),
        .rollover_flag(byte_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            byte_rcvd <= 1'b0;
        else
            byte_rcvd <= shift_en && byte_last;
    end

endmodule
